// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if
//   Bundles the instruction-fetch bus: the ROM port (chip enable, address,
//   read data), the redirect inputs (flush/branch) and the valid/ready
//   handshake toward the ID stage.
//   master : the fetch unit (drives ROM request and ID outputs)
//   slave  : the surrounding environment (ROM, ctrl, ID stage)
interface if_fetch_unit_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_flag;
    logic [31:0] br_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    modport master (
        output rom_ce, rom_addr, id_valid, id_pc, id_inst, id_adel,
        input  rom_inst, flush, flush_pc, br_flag, br_target, id_ready
    );

    modport slave (
        input  rom_ce, rom_addr, id_valid, id_pc, id_inst, id_adel,
        output rom_inst, flush, flush_pc, br_flag, br_target, id_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch initiator for the instruction ROM. Holds the PC, drives
//   the ROM chip enable and address, captures the combinational ROM word and
//   queues {pc, inst, adel} in a small buffer that feeds ID over valid/ready.
//   Flush (from ctrl, highest priority) and branch (from ID) redirects empty
//   the buffer and discard the in-flight ROM word.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : if_fetch_unit_if.master (ROM port, redirects, ID handshake)
//
//   Parameters:
//     RESET_PC  : first fetch address after reset (word aligned)
//     BUF_DEPTH : fetch buffer entries (>=2, power of two)
//
//   Optional feature macro IF_ADEL_CHECK_EN:
//     defined   : misaligned redirect targets are loaded as-is; the next push
//                 enqueues an address-error entry and fetch stops until the
//                 next redirect.
//     undefined : redirect targets are word aligned on load, id_adel is 0.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | just out of reset, rom_ce low, nothing fetched
//   ST_RUN  | fetching; left only through reset
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              rom_ce_q, rom_ce_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]       buf_pc_q   [BUF_DEPTH];
    logic [31:0]       buf_pc_d   [BUF_DEPTH];
    logic [31:0]       buf_inst_q [BUF_DEPTH];
    logic [31:0]       buf_inst_d [BUF_DEPTH];
`ifdef IF_ADEL_CHECK_EN
    logic              buf_adel_q [BUF_DEPTH];
    logic              buf_adel_d [BUF_DEPTH];
`endif

    logic              run;
    logic              id_valid;
    logic              redirect;
    logic              pop;
    logic              push;
    logic [31:0]       target;

    assign run      = (state_q == ST_RUN);
    assign id_valid = (count_q != '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rom_ce_d   = rom_ce_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
`ifdef IF_ADEL_CHECK_EN
        buf_adel_d = buf_adel_q;
`endif

        redirect = run & (bus.flush | bus.br_flag);
        target   = bus.flush ? bus.flush_pc : bus.br_target;
`ifndef IF_ADEL_CHECK_EN
        target   = target & 32'hFFFF_FFFC;
`endif
        pop  = id_valid & bus.id_ready;
        // A full buffer still accepts a word when the head leaves this cycle.
        push = run & rom_ce_q & ~bus.flush & ~bus.br_flag
             & ((count_q < CNT_FULL) | pop);

        case (state_q)
            ST_IDLE: begin
                state_d  = ST_RUN;
                rom_ce_d = 1'b1;
            end
            ST_RUN: begin
                if (redirect) begin
                    // Any coincident pop is dropped along with the buffer.
                    pc_d     = target;
                    rom_ce_d = 1'b1;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                end else begin
                    if (push) begin
                        buf_pc_d[wr_ptr_q] = pc_q;
`ifdef IF_ADEL_CHECK_EN
                        if (pc_q[1:0] != 2'b00) begin
                            // Misaligned fetch: report it once, then park.
                            buf_inst_d[wr_ptr_q] = 32'h0;
                            buf_adel_d[wr_ptr_q] = 1'b1;
                            rom_ce_d             = 1'b0;
                        end else begin
                            buf_inst_d[wr_ptr_q] = bus.rom_inst;
                            buf_adel_d[wr_ptr_q] = 1'b0;
                        end
`else
                        buf_inst_d[wr_ptr_q] = bus.rom_inst;
`endif
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        pc_d     = pc_q + 32'd4;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            rom_ce_q   <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            buf_pc_q   <= '{default: '0};
            buf_inst_q <= '{default: '0};
`ifdef IF_ADEL_CHECK_EN
            buf_adel_q <= '{default: 1'b0};
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rom_ce_q   <= rom_ce_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
`ifdef IF_ADEL_CHECK_EN
            buf_adel_q <= buf_adel_d;
`endif
        end
    end

    assign bus.rom_ce   = rom_ce_q;
    assign bus.rom_addr = pc_q;
    assign bus.id_valid = id_valid;
    assign bus.id_pc    = id_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;
    assign bus.id_inst  = id_valid ? buf_inst_q[rd_ptr_q] : 32'h0;
`ifdef IF_ADEL_CHECK_EN
    assign bus.id_adel  = id_valid ? buf_adel_q[rd_ptr_q] : 1'b0;
`else
    assign bus.id_adel  = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef IF_ADEL_CHECK_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } ent_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign bus.rom_inst = rom_word(bus.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fetch stream as a queue of expected ID entries.
    bit          m_run;
    bit          m_ce;
    logic [31:0] m_pc;
    ent_t        q[$];

    function automatic void model_reset();
        m_run = 1'b0;
        m_ce  = 1'b0;
        m_pc  = RPC;
        q.delete();
    endfunction

    function automatic logic [65:0] exp_id();
        if (q.size() == 0) return 66'h0;
        return {1'b1, q[0].pc, q[0].inst, q[0].adel};
    endfunction

    function automatic logic [65:0] act_id();
        return {bus.id_valid, bus.id_pc, bus.id_inst, bus.id_adel};
    endfunction

    // Advance the model with the inputs presented this cycle, then clock.
    task automatic tick();
        ent_t e;
        bit   pop, push;
        int   sz;
        if (rst_n) begin
            if (!m_run) begin
                m_run = 1'b1;
                m_ce  = 1'b1;
            end else begin
                sz  = q.size();
                pop = (sz > 0) && bus.id_ready;
                if (bus.flush || bus.br_flag) begin
                    q.delete();
                    m_pc = bus.flush ? bus.flush_pc : bus.br_target;
                    if (!ADEL) m_pc[1:0] = 2'b00;
                    m_ce = 1'b1;
                end else begin
                    push = m_ce && ((sz < DEPTH) || pop);
                    if (pop) void'(q.pop_front());
                    if (push) begin
                        e.pc = m_pc;
                        if (ADEL && m_pc[1:0] != 2'b00) begin
                            e.inst = 32'h0;
                            e.adel = 1'b1;
                            m_ce   = 1'b0;
                        end else begin
                            e.inst = rom_word(m_pc);
                            e.adel = 1'b0;
                        end
                        q.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush     = 1'b0;
        bus.flush_pc  = 32'h0;
        bus.br_flag   = 1'b0;
        bus.br_target = 32'h0;
        bus.id_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (act_id() !== 66'h0) begin
            errors++;
            $display("FAIL reset_id act=%h exp=0", act_id());
        end
        checks++;
        if ({bus.rom_ce, bus.rom_addr} !== {1'b0, RPC}) begin
            errors++;
            $display("FAIL reset_rom act=%b/%h exp=0/%h", bus.rom_ce, bus.rom_addr, RPC);
        end
    endtask

    task automatic test_stream();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (act_id() !== exp_id()) begin
                errors++;
                $display("FAIL stream_c%0d act=%h exp=%h", i, act_id(), exp_id());
            end
            if (i == 1) begin
                checks++;
                if ({bus.id_valid, bus.id_pc, bus.id_inst} !== {1'b1, 32'h0, rom_word(32'h0)}) begin
                    errors++;
                    $display("FAIL stream_first act=%b/%h/%h exp=1/0/%h",
                             bus.id_valid, bus.id_pc, bus.id_inst, rom_word(32'h0));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (act_id() !== exp_id()) begin
                errors++;
                $display("FAIL bp_hold_c%0d act=%h exp=%h", i, act_id(), exp_id());
            end
        end
        checks++;
        if ({bus.rom_addr, bus.id_pc, bus.id_valid} !== {32'h8, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL bp_sat act=pc %h id_pc %h v %b exp=pc 8 id_pc 0 v 1",
                     bus.rom_addr, bus.id_pc, bus.id_valid);
        end
        bus.id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({bus.id_valid, bus.id_pc} !== {1'b1, 32'(4 * (k + 1))}) begin
                errors++;
                $display("FAIL bp_drain_c%0d act=%b/%h exp=1/%h", k, bus.id_valid, bus.id_pc, 4 * (k + 1));
            end
        end
    endtask

    task automatic test_branch();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.br_flag   = 1'b1;
        bus.br_target = 32'h40;
        tick();
        bus.br_flag = 1'b0;
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_bubble act=%b exp=0", bus.id_valid);
        end
        tick();
        checks++;
        if ({bus.id_valid, bus.id_pc} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL br_target act=%b/%h exp=1/40", bus.id_valid, bus.id_pc);
        end
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (act_id() !== exp_id()) begin
                errors++;
                $display("FAIL br_after_c%0d act=%h exp=%h", i, act_id(), exp_id());
            end
        end
    endtask

    task automatic test_flush_priority();
        bus.flush     = 1'b1;
        bus.flush_pc  = 32'h380;
        bus.br_flag   = 1'b1;
        bus.br_target = 32'h40;
        tick();
        bus.flush   = 1'b0;
        bus.br_flag = 1'b0;
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL fl_bubble act=%b exp=0", bus.id_valid);
        end
        tick();
        checks++;
        if ({bus.id_valid, bus.id_pc} !== {1'b1, 32'h380}) begin
            errors++;
            $display("FAIL fl_target act=%b/%h exp=1/380", bus.id_valid, bus.id_pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (act_id() !== exp_id() || bus.id_pc === 32'h40) begin
                errors++;
                $display("FAIL fl_after_c%0d act=%h exp=%h", i, act_id(), exp_id());
            end
        end
    endtask

    task automatic test_wrap_async();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        bus.id_ready  = 1'b1;
        bus.br_flag   = 1'b1;
        bus.br_target = 32'hFFFF_FFF8;
        tick();
        bus.br_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (act_id() !== exp_id() || bus.id_pc !== want[i]) begin
                errors++;
                $display("FAIL wrap_c%0d act=%h exp=%h want_pc=%h", i, act_id(), exp_id(), want[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.id_valid, bus.rom_ce} !== 2'b00) begin
            errors++;
            $display("FAIL async_rst act=v%b ce%b exp=v0 ce0", bus.id_valid, bus.rom_ce);
        end
        model_reset();
    endtask

    task automatic test_adel();
        do_reset();
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.br_flag   = 1'b1;
        bus.br_target = 32'h42;
        tick();
        bus.br_flag = 1'b0;
        tick();
`ifdef IF_ADEL_CHECK_EN
        checks++;
        if ({act_id(), bus.rom_ce} !== {1'b1, 32'h42, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL adel_entry act=%h ce%b exp=1/42/0/1 ce0", act_id(), bus.rom_ce);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.id_valid !== 1'b0 || bus.rom_ce !== 1'b0 || act_id() !== exp_id()) begin
                errors++;
                $display("FAIL adel_stop_c%0d act=%h ce%b exp=%h ce0", i, act_id(), bus.rom_ce, exp_id());
            end
        end
        bus.br_flag   = 1'b1;
        bus.br_target = 32'h80;
        tick();
        bus.br_flag = 1'b0;
        checks++;
        if (bus.rom_ce !== 1'b1) begin
            errors++;
            $display("FAIL adel_resume_ce act=%b exp=1", bus.rom_ce);
        end
        tick();
        checks++;
        if ({bus.id_valid, bus.id_pc, bus.id_adel} !== {1'b1, 32'h80, 1'b0}) begin
            errors++;
            $display("FAIL adel_resume act=%b/%h/%b exp=1/80/0", bus.id_valid, bus.id_pc, bus.id_adel);
        end
`else
        checks++;
        if ({bus.id_valid, bus.id_pc, bus.id_adel, bus.rom_ce} !== {1'b1, 32'h40, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL align_mask act=%b/%h/%b ce%b exp=1/40/0 ce1",
                     bus.id_valid, bus.id_pc, bus.id_adel, bus.rom_ce);
        end
`endif
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] t;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.id_ready = ($urandom_range(0, 9) < 7);
            r            = $urandom_range(0, 99);
            bus.br_flag  = (r < 6);
            bus.flush    = (r >= 95) || (r == 3);
            t            = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom);
            bus.br_target = t;
            bus.flush_pc  = ($urandom & 32'h0000_0FFC) | 32'h0001_0000;
            tick();
            checks++;
            if (act_id() !== exp_id() || {bus.rom_ce, bus.rom_addr} !== {m_ce, m_pc}) begin
                errors++;
                $display("FAIL rand_c%0d act=%h ce%b a%h exp=%h ce%b a%h",
                         i, act_id(), bus.rom_ce, bus.rom_addr, exp_id(), m_ce, m_pc);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_flush_priority();
        test_wrap_async();
        test_adel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
